// File: rtl/load_store_unit.sv
// Memory-access stage: word-aligned loads/stores with sub-word extraction,
// read-modify-write for SB/SH, and fault reporting that never touches memory.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            resp_illegal,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;

  logic              req_ill;
  logic              req_mis;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;
  logic [XLEN-1:0]   merged;

  always_comb begin
    req_ill = 1'b0;
    if (req_write) begin
      req_ill = (req_funct3 > 3'd2);
    end else begin
      unique case (req_funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101: req_ill = 1'b0;
        default:        req_ill = 1'b1;
      endcase
    end
  end

  // Illegal wins over misaligned, so only legal sizes are checked here.
  always_comb begin
    req_mis = 1'b0;
    if (!req_ill) begin
      unique case (req_funct3[1:0])
        2'b01:   req_mis = req_addr[0];
        2'b10:   req_mis = |req_addr[1:0];
        default: req_mis = 1'b0;
      endcase
    end
  end

  assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = mem_rdata;
    unique case (f3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = word_q;
    unique case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    write_d = write_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          write_d = req_write;
          mis_d   = req_mis;
          ill_d   = req_ill;
          if (req_ill || req_mis) begin
            rdata_d = '0;
            state_d = RESP;
          end else if (req_write && req_funct3 == 3'b010) begin
            state_d = WR;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        word_d = mem_rdata;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = ld_ext;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_re          = (state_q == RD_ISSUE);
  assign mem_we          = (state_q == WR);
  assign mem_addr        = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata       = (state_q == WR) ? merged : '0;
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = (state_q == RESP) && mis_q;
  assign resp_illegal    = (state_q == RESP) && ill_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small synchronous memory.
// Expected values are hand-computed from the memory image the bench writes.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];

  int n_checks;
  int n_fail;

  int          lat;
  int          re_n;
  int          we_n;
  int          both_n;
  logic [31:0] seen_addr;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_ill;

  load_store_unit #(.XLEN(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_illegal    (resp_illegal),
    .mem_addr        (mem_addr),
    .mem_re          (mem_re),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request; inputs are scrambled right after acceptance.
  task automatic run(input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    bit got;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~w;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0ff4;
    req_wdata  = 32'h5555_5555;
    lat = 99; re_n = 0; we_n = 0; both_n = 0;
    seen_addr = 32'hffff_ffff;
    r_rdata = 32'hxxxx_xxxx; r_mis = 1'bx; r_ill = 1'bx;
    got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) we_n++;
      if (mem_re && mem_we) both_n++;
      if (mem_re || mem_we) seen_addr = mem_addr;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        r_rdata = resp_rdata;
        r_mis = resp_misaligned;
        r_ill = resp_illegal;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b000;
    req_addr = '0;
    req_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    check("rst_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
    reset = 1'b1;

    run(1'b1, 3'b010, 32'h28, 32'hdeadbeef);
    check("sw0_lat", 32'(lat), 32'd2);
    check("sw0_we", 32'(we_n), 32'd1);
    check("sw0_re", 32'(re_n), 32'd0);
    check("sw0_mem", mem[10], 32'hdeadbeef);

    run(1'b0, 3'b010, 32'h28, 32'h0);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_re", 32'(re_n), 32'd1);
    check("lw_we", 32'(we_n), 32'd0);
    check("lw_data", r_rdata, 32'hdeadbeef);
    check("lw_addr", seen_addr, 32'h28);

    run(1'b0, 3'b000, 32'h2b, 32'h0);
    check("lb_data", r_rdata, 32'hffffffde);
    run(1'b0, 3'b100, 32'h29, 32'h0);
    check("lbu_data", r_rdata, 32'h000000be);
    run(1'b0, 3'b001, 32'h2a, 32'h0);
    check("lh_data", r_rdata, 32'hffffdead);
    run(1'b0, 3'b101, 32'h28, 32'h0);
    check("lhu_data", r_rdata, 32'h0000beef);
    check("lhu_flags", {30'd0, r_mis, r_ill}, 32'd0);

    run(1'b1, 3'b000, 32'h29, 32'h0000_0012);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_re", 32'(re_n), 32'd1);
    check("sb_we", 32'(we_n), 32'd1);
    check("sb_both", 32'(both_n), 32'd0);
    check("sb_addr", seen_addr, 32'h28);
    check("sb_rdata", r_rdata, 32'd0);
    check("sb_mem", mem[10], 32'hdead12ef);

    run(1'b1, 3'b001, 32'h2a, 32'h1234_cafe);
    check("sh_lat", 32'(lat), 32'd4);
    check("sh_mem", mem[10], 32'hcafe12ef);

    run(1'b1, 3'b010, 32'h2c, 32'hbadab00f);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we", 32'(we_n), 32'd1);
    check("sw_mem", mem[11], 32'hbadab00f);
    check("sw_nbr", mem[10], 32'hcafe12ef);

    run(1'b0, 3'b010, 32'h2a, 32'h0);
    check("lwmis_lat", 32'(lat), 32'd1);
    check("lwmis_flags", {30'd0, r_mis, r_ill}, 32'd2);
    check("lwmis_rdata", r_rdata, 32'd0);
    check("lwmis_mem", 32'(re_n + we_n), 32'd0);

    run(1'b1, 3'b001, 32'h29, 32'hffff_ffff);
    check("shmis_flags", {30'd0, r_mis, r_ill}, 32'd2);
    check("shmis_we", 32'(we_n), 32'd0);
    check("shmis_mem", mem[10], 32'hcafe12ef);

    run(1'b0, 3'b011, 32'h2a, 32'h0);
    check("ill_ld_flags", {30'd0, r_mis, r_ill}, 32'd1);
    check("ill_ld_lat", 32'(lat), 32'd1);
    run(1'b1, 3'b100, 32'h29, 32'h0);
    check("ill_st_flags", {30'd0, r_mis, r_ill}, 32'd1);
    check("ill_st_we", 32'(we_n), 32'd0);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h28; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rmid_re", 32'(mem_re), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("rmid_ready", 32'(req_ready), 32'd1);
    check("rmid_we", 32'(mem_we), 32'd0);
    check("rmid_rvalid", 32'(resp_valid), 32'd0);
    we_n = 0; lat = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) we_n++;
      if (resp_valid) lat++;
    end
    check("rmid_we_after", 32'(we_n), 32'd0);
    check("rmid_rv_after", 32'(lat), 32'd0);
    check("rmid_mem", mem[10], 32'hcafe12ef);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h28;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_re1", 32'(mem_re), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_resp", 32'(resp_valid), 32'd1);
    check("b2b_busy", 32'(req_ready), 32'd0);
    check("b2b_data", resp_rdata, 32'hcafe12ef);
    @(negedge clk);
    check("b2b_idle", 32'(req_ready), 32'd1);
    check("b2b_hold", resp_rdata, 32'hcafe12ef);
    @(negedge clk);
    check("b2b_re2", 32'(mem_re), 32'd1);
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 5 && lat == 0; c++) begin
      @(negedge clk);
      if (resp_valid) lat = c;
    end
    check("b2b_lat2", 32'(lat), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
